axi_dm_mm2s_responder: RTL

- Command/status responder for the datamover command interface: the MM2S end that executes issued commands.
- Accepts 72-bit datamover commands on a stream slave and issues word-aligned AXI4 INCR read bursts, split at max-burst and 4 KB boundaries.
- Forwards read data onto an AXI4-Stream master and returns one 8-bit status per command.
- Sits between the stream command issuer and the ACP/HP AXI read port.

---
 rtl/axi_dm_pkg.sv | 52 +++++
 rtl/axi_dm_cmd_skid.sv | 48 ++++
 rtl/axi_dm_mm2s_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dm_pkg.sv
// Shared definitions for the MM2S datamover responder: command and
// status field layout, AXI constants and the FSM state encoding.
package axi_dm_pkg;

    localparam int CMD_W   = 72;
    localparam int BTT_LO  = 0;
    localparam int BTT_HI  = 22;
    localparam int EOF_BIT = 30;
    localparam int ADDR_LO = 32;
    localparam int ADDR_HI = 63;
    localparam int TAG_LO  = 64;
    localparam int TAG_HI  = 67;

    localparam int BTT_W   = BTT_HI - BTT_LO + 1;
    localparam int BEATS_W = BTT_W - 2;

    localparam int STS_OKAY_BIT   = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;

    localparam logic [2:0] ARSIZE_4B    = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;

    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_AR,
        ST_DATA,
        ST_STS
    } state_e;

    typedef struct packed {
        logic [ADDR_HI-ADDR_LO:0] addr;
        logic [BTT_W-1:0]         btt;
        logic [TAG_HI-TAG_LO:0]   tag;
        logic                     eof;
    } cmd_t;

    function automatic cmd_t cmd_unpack(input logic [CMD_W-1:0] w);
        cmd_t c;
        c.addr = w[ADDR_HI:ADDR_LO];
        c.btt  = w[BTT_HI:BTT_LO];
        c.tag  = w[TAG_HI:TAG_LO];
        c.eof  = w[EOF_BIT];
        return c;
    endfunction

endpackage

// File: rtl/axi_dm_cmd_skid.sv
// Single-entry command buffer; holds one command while the responder
// is busy. A bypassed command is consumed directly and never stored.
module axi_dm_cmd_skid
    import axi_dm_pkg::*;
#(
    parameter int W = CMD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         bypass,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (m_ready) begin
            full_d = 1'b0;
        end
        if (s_valid && s_ready && !bypass) begin
            full_d = 1'b1;
            data_d = s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign s_ready = ~full_q;
    assign m_valid = full_q;
    assign m_data  = data_q;

endmodule

// File: rtl/axi_dm_mm2s_responder.sv
// MM2S datamover command responder: command -> INCR read bursts -> stream.
// Optional one-entry command buffer enabled by AXI_DM_CMD_SKID_EN.
module axi_dm_mm2s_responder
    import axi_dm_pkg::*;
#(
    parameter int C_S_AXIS_CMD_DATA_WIDTH = 72,
    parameter int C_M_AXIS_STS_DATA_WIDTH = 8,
    parameter int C_AXI_ADDR_WIDTH        = 32,
    parameter int C_AXI_DATA_WIDTH        = 32,
    parameter int C_MAX_BURST             = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               S_AXIS_CMD_TVALID,
    output logic                               S_AXIS_CMD_TREADY,
    input  logic [C_S_AXIS_CMD_DATA_WIDTH-1:0] S_AXIS_CMD_TDATA,
    output logic                               M_AXIS_STS_TVALID,
    input  logic                               M_AXIS_STS_TREADY,
    output logic [C_M_AXIS_STS_DATA_WIDTH-1:0] M_AXIS_STS_TDATA,
    output logic [C_AXI_ADDR_WIDTH-1:0]        M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]        M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]        M_AXIS_TDATA,
    output logic                               M_AXIS_TVALID,
    input  logic                               M_AXIS_TREADY,
    output logic                               M_AXIS_TLAST,
    output logic                               busy
);

    state_e                      state_q, state_d;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BTT_W-1:0]            btt_q, btt_d;
    logic [3:0]                  tag_q, tag_d;
    logic                        eof_q, eof_d;
    logic [BEATS_W-1:0]          beats_rem_q, beats_rem_d;
    logic [8:0]                  burst_cnt_q, burst_cnt_d;
    logic [7:0]                  arlen_q, arlen_d;
    logic                        slverr_q, slverr_d;
    logic                        decerr_q, decerr_d;
    logic                        interr_q, interr_d;
    logic                        live_q;

    logic [CMD_W-1:0] cmd_word;
    logic [CMD_W-1:0] in_word;
    logic             in_valid;
    logic             take;
    logic             rd_hs;
    logic             last_beat;
    logic [8:0]       len;
    cmd_t             cmd;

    // Beats for the next burst: remaining work, capped by max burst
    // and by the words left before the next 4 KB page.
    function automatic logic [8:0] burst_len(
        input logic [BEATS_W-1:0] beats,
        input logic [9:0]         word_off
    );
        logic [10:0] page_beats;
        logic [8:0]  cap;
        page_beats = 11'd1024 - {1'b0, word_off};
        cap = (page_beats > 11'(C_MAX_BURST)) ?
              9'(C_MAX_BURST) : page_beats[8:0];
        burst_len = (beats > BEATS_W'(cap)) ? cap : beats[8:0];
    endfunction

    assign cmd_word  = S_AXIS_CMD_TDATA[CMD_W-1:0];
    assign cmd       = cmd_unpack(in_word);
    assign rd_hs     = (state_q == ST_DATA) && M_AXI_RVALID && M_AXIS_TREADY;
    assign last_beat = (burst_cnt_q == 9'd1);

`ifdef AXI_DM_CMD_SKID_EN
    logic             skid_valid;
    logic             skid_ready;
    logic             skid_bypass;
    logic [CMD_W-1:0] skid_data;

    assign skid_bypass = live_q && (state_q == ST_IDLE) && !skid_valid;

    axi_dm_cmd_skid #(.W(CMD_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (S_AXIS_CMD_TVALID && live_q),
        .s_ready (skid_ready),
        .s_data  (cmd_word),
        .bypass  (skid_bypass),
        .m_valid (skid_valid),
        .m_ready (take && skid_valid),
        .m_data  (skid_data)
    );

    assign S_AXIS_CMD_TREADY = live_q && skid_ready;
    assign in_word  = skid_valid ? skid_data : cmd_word;
    assign in_valid = skid_valid || (S_AXIS_CMD_TVALID && skid_bypass);
`else
    assign S_AXIS_CMD_TREADY = live_q && (state_q == ST_IDLE);
    assign in_word  = cmd_word;
    assign in_valid = S_AXIS_CMD_TVALID && S_AXIS_CMD_TREADY;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        btt_d       = btt_q;
        tag_d       = tag_q;
        eof_d       = eof_q;
        beats_rem_d = beats_rem_q;
        burst_cnt_d = burst_cnt_q;
        arlen_d     = arlen_q;
        slverr_d    = slverr_q;
        decerr_d    = decerr_q;
        interr_d    = interr_q;
        len         = '0;
        take        = 1'b0;
        unique case (state_q)
            ST_IDLE: take = in_valid;
            ST_CHECK: begin
                if (btt_q == '0 || addr_q[1:0] != 2'b00 ||
                    btt_q[1:0] != 2'b00) begin
                    interr_d = 1'b1;
                    state_d  = ST_STS;
                end else begin
                    beats_rem_d = btt_q[BTT_W-1:2];
                    len         = burst_len(beats_rem_d, addr_q[11:2]);
                    burst_cnt_d = len;
                    arlen_d     = 8'(len - 9'd1);
                    state_d     = ST_AR;
                end
            end
            ST_AR: begin
                if (M_AXI_ARREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rd_hs) begin
                    beats_rem_d = beats_rem_q - BEATS_W'(1);
                    burst_cnt_d = burst_cnt_q - 9'd1;
                    addr_d      = addr_q + C_AXI_ADDR_WIDTH'(4);
                    if (M_AXI_RRESP == RRESP_SLVERR) slverr_d = 1'b1;
                    if (M_AXI_RRESP == RRESP_DECERR) decerr_d = 1'b1;
                    if (M_AXI_RLAST != last_beat)    interr_d = 1'b1;
                    // The local counter, not RLAST, closes the burst.
                    if (last_beat) begin
                        if (beats_rem_d == '0) begin
                            state_d = ST_STS;
                        end else begin
                            len         = burst_len(beats_rem_d, addr_d[11:2]);
                            burst_cnt_d = len;
                            arlen_d     = 8'(len - 9'd1);
                            state_d     = ST_AR;
                        end
                    end
                end
            end
            ST_STS: begin
                if (M_AXIS_STS_TREADY) begin
                    state_d = ST_IDLE;
`ifdef AXI_DM_CMD_SKID_EN
                    take = skid_valid;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            addr_d   = cmd.addr;
            btt_d    = cmd.btt;
            tag_d    = cmd.tag;
            eof_d    = cmd.eof;
            slverr_d = 1'b0;
            decerr_d = 1'b0;
            interr_d = 1'b0;
            state_d  = ST_CHECK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            btt_q       <= '0;
            tag_q       <= '0;
            eof_q       <= 1'b0;
            beats_rem_q <= '0;
            burst_cnt_q <= '0;
            arlen_q     <= '0;
            slverr_q    <= 1'b0;
            decerr_q    <= 1'b0;
            interr_q    <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            btt_q       <= btt_d;
            tag_q       <= tag_d;
            eof_q       <= eof_d;
            beats_rem_q <= beats_rem_d;
            burst_cnt_q <= burst_cnt_d;
            arlen_q     <= arlen_d;
            slverr_q    <= slverr_d;
            decerr_q    <= decerr_d;
            interr_q    <= interr_d;
            live_q      <= 1'b1;
        end
    end

    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = ARSIZE_4B;
    assign M_AXI_ARBURST = ARBURST_INCR;
    assign M_AXI_ARVALID = (state_q == ST_AR);

    assign M_AXI_RREADY  = (state_q == ST_DATA) && M_AXIS_TREADY;
    assign M_AXIS_TVALID = (state_q == ST_DATA) && M_AXI_RVALID;
    assign M_AXIS_TDATA  = (state_q == ST_DATA) ? M_AXI_RDATA : '0;
    assign M_AXIS_TLAST  = (state_q == ST_DATA) && eof_q &&
                           (beats_rem_q == BEATS_W'(1)) && last_beat;

    assign busy = (state_q != ST_IDLE);

    // Only the most severe error is flagged: DECERR > SLVERR > INTERR.
    always_comb begin
        M_AXIS_STS_TDATA = '0;
        if (state_q == ST_STS) begin
            M_AXIS_STS_TDATA[STS_OKAY_BIT]   = ~(slverr_q | decerr_q | interr_q);
            M_AXIS_STS_TDATA[STS_DECERR_BIT] = decerr_q;
            M_AXIS_STS_TDATA[STS_SLVERR_BIT] = slverr_q & ~decerr_q;
            M_AXIS_STS_TDATA[STS_INTERR_BIT] = interr_q & ~slverr_q & ~decerr_q;
            M_AXIS_STS_TDATA[3:0]            = tag_q;
        end
    end

    assign M_AXIS_STS_TVALID = (state_q == ST_STS);

endmodule
